// File: rtl/octave_frame_sequencer.sv
// -----------------------------------------------------------------------------
// octave_frame_sequencer
//
// Frame-level controller that feeds one octave pipeline from the frame buffer.
// It runs in three phases:
//   1. It reads a WIDTH x HEIGHT 8-bit image from memory, starting at
//      base_addr, and passes each returned pixel to the octave one cycle later.
//   2. It waits for every outstanding read to return.
//   3. It streams FLUSH_ROWS rows of blanking (din = 0, blanking = 1). This
//      drains the last real rows out of the Gaussian chain and its DoG delay
//      lines.
// After that it pulses done for one cycle and returns to IDLE.
//
// Ports
//   clock, reset     clock and synchronous active-high reset
//   start            begin one frame; only sampled in IDLE
//   base_addr        address of pixel (0,0); captured when start is accepted
//   busy             high in every state except IDLE
//   done             one-cycle pulse in the DONE state
//   mem_req/addr     read request; address held stable until mem_gnt
//   mem_gnt          request accepted on mem_req & mem_gnt
//   mem_rvalid/rdata in-order read return, latency >= 1
//   oct_din          pixel (or zero during blanking) to the octave
//   oct_validin      strobe to the octave; the octave never back-pressures
//   oct_blanking     marks oct_din as blanking rather than image data
// -----------------------------------------------------------------------------
module octave_frame_sequencer #(
  parameter int WIDTH           = 420,
  parameter int HEIGHT          = 316,
  parameter int FLUSH_ROWS      = 10,
  parameter int ADDR_W          = 18,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        oct_din,
  output logic              oct_validin,
  output logic              oct_blanking
);

  // ---------------------------------------------------------------------------
  // Derived sizes
  // ---------------------------------------------------------------------------
  localparam int PIXELS = WIDTH * HEIGHT;
  localparam int CNT_W  = $clog2(PIXELS + 1);
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int COL_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W  = (FLUSH_ROWS > 1) ? $clog2(FLUSH_ROWS) : 1;

  localparam logic [CNT_W-1:0] PIXELS_C   = CNT_W'(PIXELS);
  localparam logic [OUT_W-1:0] MAX_OUT_C  = OUT_W'(MAX_OUTSTANDING);
  localparam logic [COL_W-1:0] LAST_COL_C = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW_C = ROW_W'(FLUSH_ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } state_e;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  issued_q, issued_d;            // reads granted this frame
  logic [OUT_W-1:0]  outstanding_q, outstanding_d;  // granted, not yet returned
  logic [COL_W-1:0]  col_q, col_d;                  // flush column
  logic [ROW_W-1:0]  row_q, row_d;                  // flush row
  logic [7:0]        pix_q, pix_d;                  // returned pixel, one cycle late
  logic              pix_valid_q, pix_valid_d;

  // ---------------------------------------------------------------------------
  // Shared decode
  // ---------------------------------------------------------------------------
  logic streaming;     // FETCH or DRAIN: read data is expected
  logic req;           // internal copy of mem_req
  logic grant;         // request accepted this cycle
  logic take_rvalid;   // read return accepted into the pipeline
  logic flush_last;    // final blanking cycle

  always_comb begin
    streaming  = (state_q == S_FETCH) || (state_q == S_DRAIN);
    req        = (state_q == S_FETCH) && (issued_q < PIXELS_C) &&
                 (outstanding_q < MAX_OUT_C);
    grant      = req && mem_gnt;
    // A return that arrives outside FETCH/DRAIN, or with nothing outstanding,
    // is a protocol error. It is dropped so that the counters cannot be
    // corrupted.
    take_rvalid = streaming && mem_rvalid && (outstanding_q != '0);
    flush_last  = (col_q == LAST_COL_C) && (row_q == LAST_ROW_C);
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked blocks use non-blocking assignments only. All registers in
  // one edge then see the pre-edge value of every other register, which is
  // what the hardware does.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational block assigns its outputs a default first. A path
  // that leaves a signal unassigned would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start)                  state_d = S_FETCH;
      S_FETCH: if (issued_q == PIXELS_C)   state_d = S_DRAIN;
      S_DRAIN: if (outstanding_q == '0)    state_d = S_FLUSH;
      S_FLUSH: if (flush_last)             state_d = S_DONE;
      S_DONE:                              state_d = S_IDLE;
      default:                             state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy         = (state_q != S_IDLE);
    done         = (state_q == S_DONE);
    mem_req      = req;
    // The address reads as zero when no request is made. While a request waits
    // for mem_gnt, neither issued_q nor base_q can change, so the address
    // stays stable.
    mem_addr     = req ? (base_q + ADDR_W'(issued_q)) : '0;
    oct_din      = 8'h00;
    oct_validin  = 1'b0;
    oct_blanking = 1'b0;
    unique case (state_q)
      S_FETCH, S_DRAIN: begin
        oct_din     = pix_q;
        oct_validin = pix_valid_q;
      end
      S_FLUSH: begin
        oct_validin  = 1'b1;
        oct_blanking = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    base_d        = base_q;
    issued_d      = issued_q;
    outstanding_d = outstanding_q;
    col_d         = col_q;
    row_d         = row_q;
    pix_d         = 8'h00;
    pix_valid_d   = 1'b0;

    if (state_q == S_IDLE) begin
      if (start) begin
        base_d        = base_addr;
        issued_d      = '0;
        outstanding_d = '0;
        col_d         = '0;
        row_d         = '0;
      end
    end else begin
      if (grant) issued_d = issued_q + CNT_W'(1);

      // A grant and a return in the same cycle leave the count unchanged.
      // req is gated on outstanding_q < MAX, so the count stays within bound.
      unique case ({grant, take_rvalid})
        2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
        2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
        default: outstanding_d = outstanding_q;
      endcase

      // Returned data goes straight to the octave one cycle later. There is
      // no buffering, so gaps in mem_rvalid appear as gaps in oct_validin.
      if (take_rvalid) begin
        pix_d       = mem_rdata;
        pix_valid_d = 1'b1;
      end

      if (state_q == S_FLUSH) begin
        if (col_q == LAST_COL_C) begin
          col_d = '0;
          row_d = flush_last ? '0 : row_q + ROW_W'(1);
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      base_q        <= '0;
      issued_q      <= '0;
      outstanding_q <= '0;
      col_q         <= '0;
      row_q         <= '0;
      pix_q         <= 8'h00;
      pix_valid_q   <= 1'b0;
    end else begin
      base_q        <= base_d;
      issued_q      <= issued_d;
      outstanding_q <= outstanding_d;
      col_q         <= col_d;
      row_q         <= row_d;
      pix_q         <= pix_d;
      pix_valid_q   <= pix_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------------
  a_outstanding_bound: assert property (
    @(posedge clock) disable iff (reset) outstanding_q <= MAX_OUT_C);

  a_request_held: assert property (
    @(posedge clock) disable iff (reset)
      (mem_req && !mem_gnt) |=> (mem_req && $stable(mem_addr)));

endmodule
